// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM port arbiter: memory op
// codes, byte-enable patterns, FSM state encoding and the alignment rule.
package mem_port_arbiter_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_D_BUS,
        ARB_I_BUS,
        ARB_RESP
    } arb_state_e;

    // Halves need an even address, words a 4-byte aligned one; bytes never fault.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = off[0];
            OP_LW, OP_SW:         mis = (off != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data placement with byte enables,
// and load extraction with sign/zero extension.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [3:0]  st_op_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [3:0]  ld_op_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_rdata_o
);

    logic [31:0] ld_shifted;

    always_comb begin
        st_be_o    = BE_WORD;
        st_wdata_o = st_wdata_i;
        case (st_op_i)
            OP_SB: begin
                st_be_o    = BE_BYTE << st_off_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            OP_SH: begin
                st_be_o    = BE_HALF << st_off_i;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: begin
                st_be_o    = BE_WORD;
                st_wdata_o = st_wdata_i;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before extending it.
    always_comb begin
        ld_shifted = ld_word_i >> {ld_off_i, 3'b000};
        case (ld_op_i)
            OP_LB:   ld_rdata_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            OP_LBU:  ld_rdata_o = {24'h000000, ld_shifted[7:0]};
            OP_LH:   ld_rdata_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            OP_LHU:  ld_rdata_o = {16'h0000, ld_shifted[15:0]};
            default: ld_rdata_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and the MEM
// stage, running each access as a request/ack bus transaction with timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    output logic                  i_ack_o,
    output logic                  i_err_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [3:0]            d_op_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_ack_o,
    output logic                  d_err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_ack_i
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int SV_W = $clog2(STARVE_MAX + 1);

    arb_state_e            state_q, state_d;
    logic [SV_W-1:0]       starve_q, starve_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [3:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  i_ack_q, i_ack_d;
    logic                  i_err_q, i_err_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic                  d_ack_q, d_ack_d;
    logic                  d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] ld_rdata;
    logic                  fetch_starved;

    mem_lane_align u_align (
        .st_op_i    (d_op_i),
        .st_off_i   (d_addr_i[1:0]),
        .st_wdata_i (d_wdata_i),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .ld_word_i  (bus_rdata_i),
        .ld_rdata_o (ld_rdata)
    );

    assign fetch_starved = i_req_i && (starve_q == SV_W'(STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        to_cnt_d    = to_cnt_q;
        op_d        = op_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        i_rdata_d   = '0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = '0;

        case (state_q)
            ARB_IDLE: begin
                to_cnt_d  = '0;
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
                if (d_req_i && !fetch_starved) begin
                    op_d  = d_op_i;
                    off_d = d_addr_i[1:0];
                    // A data grant can only happen here with starve below its cap.
                    if (i_req_i) begin
                        starve_d = starve_q + 1'b1;
                    end
                    if (is_misaligned(d_op_i, d_addr_i[1:0])) begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b1;
                        state_d = ARB_RESP;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = d_we_i;
                        bus_addr_d  = {d_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        bus_be_d    = st_be;
                        bus_wdata_d = st_wdata;
                        state_d     = ARB_D_BUS;
                    end
                end else if (i_req_i) begin
                    starve_d = '0;
                    if (i_addr_i[1:0] != 2'b00) begin
                        i_ack_d = 1'b1;
                        i_err_d = 1'b1;
                        state_d = ARB_RESP;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = {i_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        bus_be_d    = BE_WORD;
                        bus_wdata_d = '0;
                        state_d     = ARB_I_BUS;
                    end
                end
            end

            ARB_D_BUS, ARB_I_BUS: begin
                // to_cnt_d is the number of cycles bus_req_o has been high so far.
                to_cnt_d = to_cnt_q + 1'b1;
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = ARB_RESP;
                    if (state_q == ARB_D_BUS) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = bus_we_q ? '0 : ld_rdata;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus_rdata_i;
                    end
                end else if (to_cnt_d == TO_W'(TIMEOUT)) begin
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = ARB_RESP;
                    if (state_q == ARB_D_BUS) begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b1;
                    end else begin
                        i_ack_d = 1'b1;
                        i_err_d = 1'b1;
                    end
                end
            end

            ARB_RESP: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            starve_q    <= '0;
            to_cnt_q    <= '0;
            op_q        <= '0;
            off_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            to_cnt_q    <= to_cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;
    assign i_ack_o     = i_ack_q;
    assign i_err_o     = i_err_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign d_err_o     = d_err_q;
    assign d_rdata_o   = d_rdata_q;

endmodule
